convolution_fp_kernel_stage: RTL and testbench

Front-end staging block for the floating-point convolution datapath. It accepts one pixel window per beat, attaches a per-beat selectable kernel from a multi-bank, double-buffered kernel store, and applies optional zero-padding at image borders. Output is registered with valid/ready backpressure. It sits between the window generator and the convolution multiply/accumulate core and replaces the fixed single-kernel, no-backpressure window/kernel bundle.

---
 rtl/convolution_fp_kernel_stage_if.sv | 63 ++++++
 rtl/convolution_fp_kernel_stage.sv | 276 +++++++++++++++++++++++++++
 tb/tb_convolution_fp_kernel_stage.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/convolution_fp_kernel_stage_if.sv
// -----------------------------------------------------------------------------
// convolution_fp_kernel_stage_if
// Beat-stream bundle between the window generator, the kernel staging stage
// and the convolution multiply/accumulate core.
//
// Input stream (generator -> stage):
//   window_i  pixel window, centre element at (row_i, col_i)
//   col_i     centre column
//   row_i     centre row
//   ksel_i    kernel bank to attach to this beat
//   pad_en_i  1 = zero window elements that fall outside the image
//   valid_i   beat valid
//   ready_o   beat accepted when valid_i && ready_o
// Output stream (stage -> MAC core):
//   window_o  masked window
//   kernel_o  active kernel of the selected bank
//   col_o     passthrough column
//   row_o     passthrough row
//   valid_o   output beat valid
//   ready_i   downstream ready
//
// The master modport is the side that produces input beats and consumes the
// output beats; the slave modport is the staging stage itself.
// -----------------------------------------------------------------------------
interface convolution_fp_kernel_stage_if #(
   parameter int FP_WIDTH      = 32,
   parameter int WINDOW_HEIGHT = 3,
   parameter int WINDOW_WIDTH  = 3,
   parameter int KSEL_W        = 1
);

   typedef logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH-1:0] win_t;

   win_t              window_i;
   logic [15:0]       col_i;
   logic [15:0]       row_i;
   logic [KSEL_W-1:0] ksel_i;
   logic              pad_en_i;
   logic              valid_i;
   logic              ready_o;

   win_t              window_o;
   win_t              kernel_o;
   logic [15:0]       col_o;
   logic [15:0]       row_o;
   logic              valid_o;
   logic              ready_i;

   modport master (
      output window_i, col_i, row_i, ksel_i, pad_en_i, valid_i,
      input  ready_o,
      input  window_o, kernel_o, col_o, row_o, valid_o,
      output ready_i
   );

   modport slave (
      input  window_i, col_i, row_i, ksel_i, pad_en_i, valid_i,
      output ready_o,
      output window_o, kernel_o, col_o, row_o, valid_o,
      input  ready_i
   );

endinterface

// File: rtl/convolution_fp_kernel_stage.sv
// -----------------------------------------------------------------------------
// convolution_fp_kernel_stage
// Front-end staging for the floating-point convolution datapath. Each accepted
// beat carries one pixel window; the stage attaches the active kernel of the
// bank chosen by ksel_i, optionally zeroes window elements lying outside the
// image, and presents the result through a registered output with a one-entry
// skid buffer so valid/ready backpressure never drops or duplicates a beat.
//
// Kernel store: each bank has a shadow copy (filled coefficient by coefficient
// through the kload_* port, row-major) and an active copy used by the beats.
// A completed shadow load raises kpending_o[bank]; the shadow is copied into
// the active copy on the next accepted beat at image position (0,0), so kernel
// swaps always happen on a frame boundary.
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-low reset
//   bus            beat streams (slave side), see convolution_fp_kernel_stage_if
//   kload_valid_i  one coefficient write this cycle
//   kload_bank_i   bank being loaded
//   kload_data_i   coefficient value
//   kpending_o     per bank: shadow fully loaded, waiting for frame-start commit
//
// Words are never interpreted: NaN, infinities and denormals pass bit-exact.
// -----------------------------------------------------------------------------
module convolution_fp_kernel_stage #(
   parameter int EXP_WIDTH     = 8,
   parameter int FRAC_WIDTH    = 23,
   parameter int WINDOW_WIDTH  = 3,
   parameter int WINDOW_HEIGHT = 3,
   parameter int NUM_KERNELS   = 2,
   parameter int IMAGE_WIDTH   = 640,
   parameter int IMAGE_HEIGHT  = 480,
   localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
   localparam int KSEL_W       = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
   localparam int KIDX_N       = WINDOW_HEIGHT * WINDOW_WIDTH
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   convolution_fp_kernel_stage_if.slave bus,
   input  logic                         kload_valid_i,
   input  logic [KSEL_W-1:0]            kload_bank_i,
   input  logic [FP_WIDTH_REG-1:0]      kload_data_i,
   output logic [NUM_KERNELS-1:0]       kpending_o
);

   localparam int KIDX_W = (KIDX_N > 1) ? $clog2(KIDX_N) : 1;

   // Window and kernel share one packed layout: element [r][c] sits at
   // flat index r*WINDOW_WIDTH+c, which is also the row-major load order.
   typedef logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] win_t;
   typedef logic [KIDX_N-1:0][FP_WIDTH_REG-1:0]                          kflat_t;

   typedef struct packed {
      win_t        window;
      win_t        kernel;
      logic [15:0] col;
      logic [15:0] row;
   } beat_t;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_LOADING = 1'b1
   } load_state_t;

   // Zero every element whose image position (computed in signed 17-bit
   // arithmetic) lies outside the image, when padding is enabled.
   function automatic win_t pad_window(
      input win_t        win,
      input logic [15:0] col,
      input logic [15:0] row,
      input logic        pad_en
   );
      win_t        res;
      logic [16:0] rpos;
      logic [16:0] cpos;
      logic        r_out;
      logic        c_out;
      res = win;
      for (int r = 0; r < WINDOW_HEIGHT; r++) begin
         rpos  = {1'b0, row} - 17'(WINDOW_HEIGHT / 2) + 17'(r);
         r_out = rpos[16] || (rpos[15:0] >= 16'(IMAGE_HEIGHT));
         for (int c = 0; c < WINDOW_WIDTH; c++) begin
            cpos  = {1'b0, col} - 17'(WINDOW_WIDTH / 2) + 17'(c);
            c_out = cpos[16] || (cpos[15:0] >= 16'(IMAGE_WIDTH));
            if (pad_en && (r_out || c_out)) begin
               res[r][c] = '0;
            end else begin
               res[r][c] = win[r][c];
            end
         end
      end
      return res;
   endfunction

   // ---------------------------------------------------------------- state
   load_state_t              state_r;
   logic [KSEL_W-1:0]        lbank_r;
   logic [KIDX_W-1:0]        lidx_r;
   kflat_t                   shadow_r [NUM_KERNELS];
   kflat_t                   active_r [NUM_KERNELS];
   logic [NUM_KERNELS-1:0]   kpending_r;

   beat_t                    out_r;
   logic                     out_valid_r;
   beat_t                    skid_r;
   logic                     skid_valid_r;
   logic                     ready_r;

   // ------------------------------------------------------------ comb nets
   load_state_t              state_nx_s;
   logic [KSEL_W-1:0]        lbank_nx_s;
   logic [KIDX_W-1:0]        lidx_nx_s;
   logic                     bank_ok_s;
   logic                     wr_en_s;
   logic [KIDX_W-1:0]        wr_idx_s;
   logic                     load_done_s;
   logic [NUM_KERNELS-1:0]   kpending_nx_s;

   logic                     accept_s;
   logic                     commit_s;
   logic [KSEL_W-1:0]        sel_s;
   kflat_t                   beat_kernel_s;
   beat_t                    beat_s;

   // Load FSM next state: locate the coefficient slot for this write and
   // detect the write that completes a bank.
   always_comb begin
      state_nx_s  = state_r;
      lbank_nx_s  = lbank_r;
      lidx_nx_s   = lidx_r;
      wr_en_s     = 1'b0;
      wr_idx_s    = '0;
      load_done_s = 1'b0;
      // Writes addressed to a bank that does not exist are ignored.
      bank_ok_s   = ({1'b0, kload_bank_i} < (KSEL_W + 1)'(NUM_KERNELS));
      if (kload_valid_i && bank_ok_s) begin
         wr_en_s = 1'b1;
         case (state_r)
            ST_LOADING: begin
               // A switch of bank abandons the partial load and restarts.
               if (kload_bank_i == lbank_r) begin
                  wr_idx_s = lidx_r;
               end else begin
                  wr_idx_s = '0;
               end
            end
            ST_IDLE: begin
               wr_idx_s = '0;
            end
            default: begin
               wr_idx_s = '0;
            end
         endcase
         if (wr_idx_s == KIDX_W'(KIDX_N - 1)) begin
            load_done_s = 1'b1;
            state_nx_s  = ST_IDLE;
            lbank_nx_s  = kload_bank_i;
            lidx_nx_s   = '0;
         end else begin
            state_nx_s  = ST_LOADING;
            lbank_nx_s  = kload_bank_i;
            lidx_nx_s   = wr_idx_s + KIDX_W'(1);
         end
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Load FSM state register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= ST_IDLE;
         lbank_r <= '0;
         lidx_r  <= '0;
      end else begin
         state_r <= state_nx_s;
         lbank_r <= lbank_nx_s;
         lidx_r  <= lidx_nx_s;
      end
   end

   // Beat acceptance, bank selection and commit detection.
   always_comb begin
      accept_s = bus.valid_i && ready_r;
      commit_s = accept_s && (bus.col_i == 16'd0) && (bus.row_i == 16'd0);
      if ({1'b0, bus.ksel_i} < (KSEL_W + 1)'(NUM_KERNELS)) begin
         sel_s = bus.ksel_i;
      end else begin
         sel_s = '0;
      end
      // The commit beat already sees the freshly committed kernel.
      if (commit_s && kpending_r[sel_s]) begin
         beat_kernel_s = shadow_r[sel_s];
      end else begin
         beat_kernel_s = active_r[sel_s];
      end
      beat_s.window = pad_window(bus.window_i, bus.col_i, bus.row_i, bus.pad_en_i);
      beat_s.kernel = beat_kernel_s;
      beat_s.col    = bus.col_i;
      beat_s.row    = bus.row_i;
   end

   // Pending flags: a commit clears them, a load finishing in the same cycle
   // re-arms its bank for the following frame.
   always_comb begin
      kpending_nx_s = '0;
      for (int b = 0; b < NUM_KERNELS; b++) begin
         kpending_nx_s[b] = (kpending_r[b] && !commit_s) ||
                            (load_done_s && (kload_bank_i == KSEL_W'(b)));
      end
   end

   // Kernel store: shadow writes, shadow-to-active commit, pending flags.
   // The commit reads the shadow as it was before this cycle's write.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int b = 0; b < NUM_KERNELS; b++) begin
            shadow_r[b] <= '0;
            active_r[b] <= '0;
         end
         kpending_r <= '0;
      end else begin
         for (int b = 0; b < NUM_KERNELS; b++) begin
            if (commit_s && kpending_r[b]) begin
               active_r[b] <= shadow_r[b];
            end
         end
         if (wr_en_s) begin
            shadow_r[kload_bank_i][wr_idx_s] <= kload_data_i;
         end
         kpending_r <= kpending_nx_s;
      end
   end

   // Output register with one-entry skid buffer; ready tracks "skid empty"
   // so a beat accepted while the output stalls always has a place to go.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         out_r        <= '0;
         out_valid_r  <= 1'b0;
         skid_r       <= '0;
         skid_valid_r <= 1'b0;
         ready_r      <= 1'b0;
      end else if (!out_valid_r || bus.ready_i) begin
         if (skid_valid_r) begin
            out_r        <= skid_r;
            out_valid_r  <= 1'b1;
            skid_valid_r <= 1'b0;
         end else if (accept_s) begin
            out_r        <= beat_s;
            out_valid_r  <= 1'b1;
         end else begin
            out_valid_r  <= 1'b0;
         end
         ready_r <= 1'b1;
      end else begin
         if (accept_s) begin
            skid_r       <= beat_s;
            skid_valid_r <= 1'b1;
            ready_r      <= 1'b0;
         end else begin
            ready_r      <= !skid_valid_r;
         end
      end
   end

   assign bus.ready_o  = ready_r;
   assign bus.window_o = out_r.window;
   assign bus.kernel_o = out_r.kernel;
   assign bus.col_o    = out_r.col;
   assign bus.row_o    = out_r.row;
   assign bus.valid_o  = out_valid_r;
   assign kpending_o   = kpending_r;

endmodule

// File: tb/tb_convolution_fp_kernel_stage.sv
// -----------------------------------------------------------------------------
// Bench for convolution_fp_kernel_stage. A behavioural model of the kernel
// store predicts the kernel for each accepted beat; expectations go into a
// queue at acceptance and are compared whenever valid_o is high (held outputs
// are re-compared every stalled cycle). Inputs change and outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_convolution_fp_kernel_stage;

   localparam int NK  = 3;
   localparam int FPW = 32;
   localparam int WH  = 3;
   localparam int WW  = 3;
   localparam int KN  = WH * WW;
   localparam int KSW = 2;

   typedef logic [WH-1:0][WW-1:0][FPW-1:0] win_t;

   typedef struct {
      win_t        window;
      win_t        kernel;
      logic [15:0] col;
      logic [15:0] row;
   } exp_t;

   typedef struct {
      logic [15:0] col;
      logic [15:0] row;
      logic [1:0]  ksel;
      logic        pad;
      logic [31:0] base;
      logic        step;
      logic [8:0]  zmask;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst_i = 1'b0;
   logic              kload_valid;
   logic [KSW-1:0]    kload_bank;
   logic [FPW-1:0]    kload_data;
   logic [NK-1:0]     kpending;

   convolution_fp_kernel_stage_if #(
      .FP_WIDTH(FPW), .WINDOW_HEIGHT(WH), .WINDOW_WIDTH(WW), .KSEL_W(KSW)
   ) bus ();

   convolution_fp_kernel_stage #(.NUM_KERNELS(NK)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .bus           (bus),
      .kload_valid_i (kload_valid),
      .kload_bank_i  (kload_bank),
      .kload_data_i  (kload_data),
      .kpending_o    (kpending)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_cyc    = 0;
   exp_t        sb [$];
   win_t        cur_exp_win;

   logic [31:0] m_shadow [NK][KN];
   logic [31:0] m_active [NK][KN];
   logic [NK-1:0] m_pend;
   bit          m_loading;
   int          m_bank;
   int          m_idx;

   function automatic void chk(input string nm, input logic [287:0] act, input logic [287:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp_v);
      end
   endfunction

   function automatic win_t mk_win(input logic [31:0] base, input logic step);
      win_t w;
      for (int r = 0; r < WH; r++)
         for (int c = 0; c < WW; c++)
            w[r][c] = step ? base + 32'(r * WW + c) : base;
      return w;
   endfunction

   function automatic void model_reset();
      for (int b = 0; b < NK; b++)
         for (int k = 0; k < KN; k++) begin
            m_shadow[b][k] = 32'h0;
            m_active[b][k] = 32'h0;
         end
      m_pend    = '0;
      m_loading = 1'b0;
      m_bank    = 0;
      m_idx     = 0;
      sb.delete();
   endfunction

   // Predicts what the coming clock edge does: beat acceptance (with commit)
   // first, then the coefficient write, so a commit sees the old shadow.
   function automatic void model_step();
      exp_t e;
      int   sel;
      int   bnk;
      if (bus.valid_i && bus.ready_o) begin
         sel = (int'(bus.ksel_i) < NK) ? int'(bus.ksel_i) : 0;
         for (int r = 0; r < WH; r++)
            for (int c = 0; c < WW; c++)
               e.kernel[r][c] = (bus.col_i == 16'd0 && bus.row_i == 16'd0 && m_pend[sel])
                                ? m_shadow[sel][r*WW+c] : m_active[sel][r*WW+c];
         e.window = cur_exp_win;
         e.col    = bus.col_i;
         e.row    = bus.row_i;
         sb.push_back(e);
         if (bus.col_i == 16'd0 && bus.row_i == 16'd0) begin
            for (int b = 0; b < NK; b++)
               if (m_pend[b]) begin
                  for (int k = 0; k < KN; k++) m_active[b][k] = m_shadow[b][k];
                  m_pend[b] = 1'b0;
               end
         end
      end
      if (kload_valid) begin
         bnk = int'(kload_bank);
         if (!m_loading || bnk != m_bank) m_idx = 0;
         m_shadow[bnk][m_idx] = kload_data;
         m_idx++;
         m_bank    = bnk;
         m_loading = 1'b1;
         if (m_idx == KN) begin
            m_pend[bnk] = 1'b1;
            m_loading   = 1'b0;
            m_idx       = 0;
         end
      end
   endfunction

   function automatic void check_outputs();
      exp_t e;
      if (bus.valid_o) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got col %0d row %0d expected no beat", bus.col_o, bus.row_o);
         end else begin
            e = sb[0];
            chk("out_window", bus.window_o, e.window);
            chk("out_kernel", bus.kernel_o, e.kernel);
            chk("out_colrow", {bus.col_o, bus.row_o}, {e.col, e.row});
            if (bus.ready_i) void'(sb.pop_front());
         end
      end
   endfunction

   task automatic cycle();
      check_outputs();
      model_step();
      @(posedge clk);
      @(negedge clk);
      n_cyc++;
   endtask

   task automatic load_word(input int bank, input logic [31:0] data);
      kload_valid = 1'b1;
      kload_bank  = KSW'(bank);
      kload_data  = data;
      cycle();
      kload_valid = 1'b0;
   endtask

   task automatic load_bank(input int bank, input logic [31:0] base, input int n);
      for (int k = 0; k < n; k++) load_word(bank, base + 32'(k));
   endtask

   task automatic send_beat(input int col, input int row, input int ksel, input logic pad,
                            input win_t w, input win_t ew);
      bit a;
      bit got;
      got = 1'b0;
      bus.valid_i  = 1'b1;
      bus.col_i    = 16'(col);
      bus.row_i    = 16'(row);
      bus.ksel_i   = KSW'(ksel);
      bus.pad_en_i = pad;
      bus.window_i = w;
      cur_exp_win  = ew;
      for (int t = 0; t < 20; t++) begin
         a = bus.ready_o;
         cycle();
         kload_valid = 1'b0;
         if (a) begin
            got = 1'b1;
            break;
         end
      end
      bus.valid_i = 1'b0;
      chk("beat_accept_timeout", 288'(got), 288'(1));
   endtask

   task automatic send_plain(input int col, input int row, input int ksel);
      win_t w;
      w = mk_win(32'h3C000000 + 32'(col * 16 + row * 256), 1'b1);
      send_beat(col, row, ksel, 1'b0, w, w);
   endtask

   task automatic drain();
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      for (int i = 0; i < 20 && sb.size() != 0; i++) cycle();
      chk("drain_empty", 288'(sb.size()), 288'(0));
      cycle();
      chk("drain_idle", 288'(bus.valid_o), 288'(0));
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_valid"},  288'(bus.valid_o),  288'(0));
      chk({tag, "_ready"},  288'(bus.ready_o),  288'(0));
      chk({tag, "_window"}, bus.window_o,       288'(0));
      chk({tag, "_kernel"}, bus.kernel_o,       288'(0));
      chk({tag, "_colrow"}, {bus.col_o, bus.row_o}, 288'(0));
      chk({tag, "_kpend"},  288'(kpending),     288'(0));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t        vt [10];
      logic [31:0] k1 [KN];
      win_t        k1w;
      win_t        w;
      win_t        ew;
      int          idx;
      int          c0;
      bit          a;

      vt[0] = '{16'd0,   16'd0,   2'd0, 1'b1, 32'h40000000, 1'b0, 9'h04F};
      vt[1] = '{16'd639, 16'd479, 2'd0, 1'b1, 32'h40000000, 1'b0, 9'h1E4};
      vt[2] = '{16'd0,   16'd0,   2'd1, 1'b0, 32'h7FC00001, 1'b1, 9'h000};
      vt[3] = '{16'd5,   16'd5,   2'd2, 1'b1, 32'h00000001, 1'b1, 9'h000};
      vt[4] = '{16'd320, 16'd0,   2'd3, 1'b1, 32'hBF800000, 1'b1, 9'h007};
      vt[5] = '{16'd639, 16'd100, 2'd1, 1'b1, 32'h3F000000, 1'b1, 9'h124};
      vt[6] = '{16'd0,   16'd479, 2'd0, 1'b1, 32'hFF800000, 1'b1, 9'h1C9};
      vt[7] = '{16'd700, 16'd10,  2'd2, 1'b1, 32'h12345678, 1'b1, 9'h1FF};
      vt[8] = '{16'd1,   16'd1,   2'd0, 1'b1, 32'h40490FDB, 1'b1, 9'h000};
      vt[9] = '{16'd638, 16'd478, 2'd1, 1'b1, 32'h80000000, 1'b1, 9'h000};

      k1 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
             32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
      for (int r = 0; r < WH; r++)
         for (int c = 0; c < WW; c++) k1w[r][c] = k1[r*WW+c];

      kload_valid  = 1'b0;
      kload_bank   = '0;
      kload_data   = '0;
      bus.valid_i  = 1'b0;
      bus.window_i = '0;
      bus.col_i    = '0;
      bus.row_i    = '0;
      bus.ksel_i   = '0;
      bus.pad_en_i = 1'b0;
      bus.ready_i  = 1'b1;
      cur_exp_win  = '0;
      model_reset();

      // Reset state, then ready rises after the first edge.
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_reset", 288'(bus.ready_o), 288'(1));

      // Load bank 0 with 1.0..9.0, commit on the (0,0) beat.
      for (int k = 0; k < KN; k++) load_word(0, k1[k]);
      chk("t1_kpend_loaded", 288'(kpending), 288'(3'b001));
      w = mk_win(32'h3F000000, 1'b1);
      send_beat(0, 0, 0, 1'b0, w, w);
      chk("t1_valid", 288'(bus.valid_o), 288'(1));
      chk("t1_kernel", bus.kernel_o, k1w);
      chk("t1_kpend_commit", 288'(kpending), 288'(3'b000));
      drain();

      // Padding vectors, back to back.
      c0 = n_cyc;
      for (int i = 0; i < 10; i++) begin
         w = mk_win(vt[i].base, vt[i].step);
         for (int r = 0; r < WH; r++)
            for (int c = 0; c < WW; c++)
               ew[r][c] = vt[i].zmask[r*WW+c] ? 32'h0 : w[r][c];
         send_beat(int'(vt[i].col), int'(vt[i].row), int'(vt[i].ksel), vt[i].pad, w, ew);
      end
      chk("throughput_cycles", 288'(n_cyc - c0), 288'(10));
      drain();

      // Backpressure: 5 stalled cycles accept exactly two beats.
      bus.ready_i = 1'b0;
      idx = 0;
      for (int t = 0; t < 5; t++) begin
         w = mk_win(32'h42000000 + 32'(idx * 64), 1'b1);
         bus.valid_i = 1'b1;
         bus.col_i = 16'(10 + idx); bus.row_i = 16'd7; bus.ksel_i = 2'd0;
         bus.pad_en_i = 1'b0; bus.window_i = w; cur_exp_win = w;
         a = bus.ready_o;
         cycle();
         if (a) idx++;
      end
      chk("stall_accepted", 288'(idx), 288'(2));
      chk("stall_ready_low", 288'(bus.ready_o), 288'(0));
      bus.ready_i = 1'b1;
      for (int t = 0; t < 20 && idx < 4; t++) begin
         w = mk_win(32'h42000000 + 32'(idx * 64), 1'b1);
         bus.valid_i = 1'b1;
         bus.col_i = 16'(10 + idx); bus.row_i = 16'd7; bus.ksel_i = 2'd0;
         bus.pad_en_i = 1'b0; bus.window_i = w; cur_exp_win = w;
         a = bus.ready_o;
         cycle();
         if (a) idx++;
      end
      chk("stall_all_sent", 288'(idx), 288'(4));
      drain();

      // Mid-frame reload of bank 1; old kernel holds until the next (0,0).
      load_bank(1, 32'h3E000000, KN);
      send_plain(0, 0, 1);
      for (int k = 0; k < KN; k++) begin
         kload_valid = 1'b1; kload_bank = 2'd1; kload_data = 32'hC0000000 + 32'(k);
         send_plain(k + 1, 3, 1);
      end
      chk("t4_kpend_mid", 288'(kpending), 288'(3'b010));
      send_plain(20, 3, 1);
      load_bank(1, 32'hC1000000, KN);
      chk("t4_kpend_reload", 288'(kpending), 288'(3'b010));
      send_plain(0, 0, 1);
      chk("t4_kpend_commit", 288'(kpending), 288'(3'b000));
      drain();

      // Abandoned partial load, then out-of-range ksel falls back to bank 0.
      load_bank(0, 32'hDEAD0000, 4);
      load_bank(1, 32'h3D000000, KN);
      chk("t5_kpend", 288'(kpending), 288'(3'b010));
      send_plain(0, 0, 3);
      chk("t5_bank0_kernel", bus.kernel_o, k1w);
      send_plain(5, 5, 1);
      drain();
      chk("t5_kpend_after", 288'(kpending), 288'(3'b000));

      // Load completing in the commit cycle arms the next frame.
      load_bank(2, 32'h44000000, KN);
      load_bank(2, 32'h45000000, KN - 1);
      kload_valid = 1'b1; kload_bank = 2'd2; kload_data = 32'h45000000 + 32'(KN - 1);
      send_plain(0, 0, 2);
      chk("t7_kpend_rearmed", 288'(kpending), 288'(3'b100));
      send_plain(0, 0, 2);
      chk("t7_kpend_clear", 288'(kpending), 288'(3'b000));
      drain();

      // Asynchronous reset mid-stream and mid-load.
      load_bank(0, 32'h46000000, KN);
      bus.ready_i = 1'b0;
      send_plain(3, 3, 0);
      send_plain(4, 3, 0);
      load_bank(1, 32'h47000000, 4);
      chk("t6_pre_valid", 288'(bus.valid_o), 288'(1));
      rst_i = 1'b0;
      #1;
      check_reset_state("async_reset");
      model_reset();
      @(negedge clk);
      rst_i = 1'b1;
      bus.ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t6_ready_after", 288'(bus.ready_o), 288'(1));
      load_bank(1, 32'h48000000, KN);
      chk("t6_kpend_loaded", 288'(kpending), 288'(3'b010));
      send_plain(0, 0, 1);
      send_plain(1, 0, 0);
      drain();
      chk("t6_kpend_final", 288'(kpending), 288'(3'b000));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
